dffram_param: RTL and testbench
===============================

// Module: dffram_param
// PURPOSE
//   Parametrised single-port flip-flop RAM, successor to the fixed 256x16 DFFRAM macro.
//   Adds: generic width/depth; per-byte write enables; a read-valid strobe; an optional
//   output pipeline register; a post-reset clear sequencer that zero-fills the array.
//   Drop-in local buffer for datapath blocks that need a deterministic initial state.
// PARAMETERS
//   WIDTH           16    data width in bits; must be a multiple of 8
//   DEPTH           256   number of words; need not be a power of two
//   AW              8     address width; must satisfy 2**AW >= DEPTH
//   CLEAR_ON_RESET  1     1: run clear sequence after reset; 0: array left unchanged
//   CLEAR_VALUE     0     WIDTH-bit value written to every word by the clear sequence
// PORTS
//   CLK    in   1          clock; all state changes on rising edge
//   RST    in   1          synchronous reset, active high
//   EN0    in   1          access enable
//   A0     in   AW         word address
//   Di0    in   WIDTH      write data
//   WE0    in   WIDTH/8    byte write enables; WE0[b] controls Di0[8b+7:8b]
//   Do0    out  WIDTH      read data
//   Dv0    out  1          read-valid; high for exactly the cycle in which Do0 holds new read data
//   BUSY   out  1          clear sequence in progress; user accesses ignored
// BEHAVIOUR
//   Reset (RST=1 at edge): Do0<=0, Dv0<=0, BUSY<=CLEAR_ON_RESET, clear pointer<=0, output pipe flushed.
//     Array contents are not reset directly.
//   FSM: IDLE, CLEAR.
//     RST -> CLEAR if CLEAR_ON_RESET, else IDLE.
//     CLEAR: each cycle writes CLEAR_VALUE to mem[ptr] and increments ptr.
//       Last write at ptr==DEPTH-1; next state IDLE; BUSY falls on the same edge.
//       BUSY is therefore high for exactly DEPTH cycles after RST falls.
//     RST asserted mid-CLEAR restarts the sequence from address 0.
//   While BUSY=1: EN0/WE0 are ignored; Do0 holds; Dv0=0.
//   Write (IDLE, EN0=1, WE0!=0): at the edge, each byte b with WE0[b]=1 is written; other bytes keep their value.
//     Do0 holds its value; Dv0=0. No write-through.
//   Read (IDLE, EN0=1, WE0==0): at the edge, Do0<=mem[A0] and Dv0<=1 (latency 1 from the sampled address).
//   Idle (EN0=0): no access; Do0 holds; Dv0=0.
//   Out of range (A0>=DEPTH): write dropped; read returns 0 with Dv0=1.
//   Back-to-back reads are allowed every cycle; Dv0 stays high continuously.
//   Write then read of the same address on the next cycle returns the new data.
// CONFIGURATION
//   DFFRAM_OUTREG_EN defined: an extra register stage follows the read mux.
//     Read latency becomes 2; Dv0 is delayed 1 cycle to match.
//     Reset clears both stages; the BUSY gate applies at the input stage.
//   DFFRAM_OUTREG_EN undefined: latency 1, as described above.
// TESTING
//   1 Reset with CLEAR_ON_RESET=1, DEPTH=256 -> BUSY high 256 cycles after RST falls;
//     then read all 256 addresses -> Do0=0x0000 each, with Dv0 pulses.
//   2 Write mem[i]=i for i=0..255 with WE0=2'b11, then read back -> Do0==i one cycle after
//     each address is applied; Dv0=1 that cycle.
//   3 Write 0xABCD to addr 5, then WE0=2'b01 with Di0=0x1234 -> read addr 5 gives 0xAB34.
//   4 Assert RST at ptr=100 during clear -> BUSY stays high; clear restarts at 0;
//     BUSY is high 256 cycles after the second RST release. A write during BUSY is ignored.
//   5 DEPTH=200, AW=8: write 0xFFFF to addr 210 -> dropped; read addr 210 -> Do0=0, Dv0=1.
//   6 With DFFRAM_OUTREG_EN: back-to-back reads of addr 1,2,3 -> data and Dv0 appear
//     2 cycles after each address, one per cycle without gaps.

Source files
------------

// File: rtl/dffram_param.sv
`default_nettype none
// ============================================================================
// Module      : dffram_param
// Description : Parametrised single-port flip-flop RAM with per-byte write
//               enables, a read-valid strobe and a post-reset clear sequencer.
//               Define DFFRAM_OUTREG_EN to add an output pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module dffram_param #(
    parameter int               WIDTH          = 16,
    parameter int               DEPTH          = 256,
    parameter int               AW             = 8,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLEAR_VALUE    = '0
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 EN0,
    input  logic [AW-1:0]        A0,
    input  logic [WIDTH-1:0]     Di0,
    input  logic [WIDTH/8-1:0]   WE0,
    output logic [WIDTH-1:0]     Do0,
    output logic                 Dv0,
    output logic                 BUSY
);

    localparam int            c_NB       = WIDTH / 8;
    localparam logic [AW:0]   c_DEPTH    = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] c_LAST     = AW'(DEPTH - 1);
    localparam logic [0:0]    c_ST_IDLE  = 1'b0;
    localparam logic [0:0]    c_ST_CLEAR = 1'b1;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [0:0]       r_state;
    logic [AW-1:0]    r_ptr;
    logic             r_busy;
    logic [WIDTH-1:0] r_rd_data;
    logic             r_rd_vld;

    logic             w_in_range;
    logic             w_access;
    logic             w_wr;
    logic             w_rd;
    logic             w_clr_wr;
    logic [WIDTH-1:0] w_bmask;
    logic [WIDTH-1:0] w_rd_mux;

    assign w_in_range = ({1'b0, A0} < c_DEPTH);
    assign w_access   = EN0 && (r_state == c_ST_IDLE) && !RST;
    assign w_wr       = w_access && (WE0 != '0) && w_in_range;
    assign w_rd       = w_access && (WE0 == '0);
    assign w_clr_wr   = (r_state == c_ST_CLEAR) && !RST;

    for (genvar b = 0; b < c_NB; b++) begin : g_bmask
        assign w_bmask[8*b +: 8] = {8{WE0[b]}};
    end

    // Out-of-range reads return zero rather than aliasing into the array
    always_comb begin
        w_rd_mux = '0;
        if (w_in_range) begin
            w_rd_mux = r_mem[A0];
        end
    end

    always_ff @(posedge CLK) begin
        if (w_clr_wr) begin
            r_mem[r_ptr] <= CLEAR_VALUE;
        end else if (w_wr) begin
            r_mem[A0] <= (r_mem[A0] & ~w_bmask) | (Di0 & w_bmask);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= CLEAR_ON_RESET ? c_ST_CLEAR : c_ST_IDLE;
            r_busy  <= CLEAR_ON_RESET;
            r_ptr   <= '0;
        end else begin
            case (r_state)
                c_ST_CLEAR: begin
                    if (r_ptr == c_LAST) begin
                        r_state <= c_ST_IDLE;
                        r_busy  <= 1'b0;
                        r_ptr   <= '0;
                    end else begin
                        r_ptr <= r_ptr + 1'b1;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_rd_data <= '0;
            r_rd_vld  <= 1'b0;
        end else begin
            r_rd_vld <= w_rd;
            if (w_rd) begin
                r_rd_data <= w_rd_mux;
            end
        end
    end

`ifdef DFFRAM_OUTREG_EN
    logic [WIDTH-1:0] r_out_data;
    logic             r_out_vld;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_out_data <= '0;
            r_out_vld  <= 1'b0;
        end else begin
            r_out_data <= r_rd_data;
            r_out_vld  <= r_rd_vld;
        end
    end

    assign Do0 = r_out_data;
    assign Dv0 = r_out_vld;
`else
    assign Do0 = r_rd_data;
    assign Dv0 = r_rd_vld;
`endif

    assign BUSY = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_dffram_param.sv
`default_nettype none
// ============================================================================
// Module      : tb_dffram_param
// Description : Randomised self-checking bench for dffram_param against a
//               word-array reference model with a latency queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dffram_param;

`ifdef DFFRAM_OUTREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        EN0 = 1'b0;
    logic [7:0]  A0  = '0;
    logic [15:0] Di0 = '0;
    logic [1:0]  WE0 = '0;
    logic [15:0] Do0;
    logic        Dv0;
    logic        BUSY;

    logic        rst_s = 1'b0;
    logic        en_s  = 1'b0;
    logic [7:0]  a_s   = '0;
    logic [15:0] di_s  = '0;
    logic [1:0]  we_s  = '0;
    logic [15:0] do_s;
    logic        dv_s;
    logic        busy_s;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word array, clear countdown and read-latency queue
    logic [15:0] mdl [0:255];
    int          clr_left = 0;
    bit          hist_v[$];
    logic [15:0] hist_d[$];
    logic        exp_busy = 1'b0;
    logic        exp_dv   = 1'b0;
    logic [15:0] exp_do   = '0;

    always #5 CLK = ~CLK;

    dffram_param #(
        .WIDTH(16), .DEPTH(256), .AW(8), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000)
    ) u_dut (
        .CLK(CLK), .RST(RST), .EN0(EN0), .A0(A0), .Di0(Di0), .WE0(WE0),
        .Do0(Do0), .Dv0(Dv0), .BUSY(BUSY)
    );

    dffram_param #(
        .WIDTH(16), .DEPTH(200), .AW(8), .CLEAR_ON_RESET(1'b1), .CLEAR_VALUE(16'h0000)
    ) u_dut_s (
        .CLK(CLK), .RST(rst_s), .EN0(en_s), .A0(a_s), .Di0(di_s), .WE0(we_s),
        .Do0(do_s), .Dv0(dv_s), .BUSY(busy_s)
    );

    task automatic step(input bit rst, input bit en, input logic [7:0] a,
                        input logic [15:0] di, input logic [1:0] we);
        bit          v;
        logic [15:0] d;
        logic [15:0] dd;
        @(negedge CLK);
        RST = rst; EN0 = en; A0 = a; Di0 = di; WE0 = we;
        @(posedge CLK);
        v = 1'b0;
        d = '0;
        if (rst) begin
            clr_left = 256;
            exp_do   = '0;
            exp_dv   = 1'b0;
            hist_v.delete();
            hist_d.delete();
        end else begin
            if (clr_left > 0) begin
                clr_left--;
                if (clr_left == 0) begin
                    foreach (mdl[i]) mdl[i] = 16'h0000;
                end
            end else if (en) begin
                if (we != 2'b00) begin
                    for (int b = 0; b < 2; b++) begin
                        if (we[b]) mdl[a][8*b +: 8] = di[8*b +: 8];
                    end
                end else begin
                    v = 1'b1;
                    d = mdl[a];
                end
            end
            hist_v.push_back(v);
            hist_d.push_back(d);
            if (hist_v.size() >= LAT) begin
                exp_dv = hist_v.pop_front();
                dd     = hist_d.pop_front();
                if (exp_dv) exp_do = dd;
            end
        end
        exp_busy = (clr_left > 0);
        #1;
    endtask

    task automatic test_reset();
        int nbusy;
        step(1, 0, 8'd0, 16'd0, 2'b00);
        step(1, 0, 8'd0, 16'd0, 2'b00);
        n_tests++;
        if (BUSY !== 1'b1 || Dv0 !== 1'b0 || Do0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_state busy=%b dv=%b do=%h required busy=1 dv=0 do=0000", BUSY, Dv0, Do0);
        end
        nbusy = (BUSY === 1'b1) ? 1 : 0;
        for (int i = 0; i < 262; i++) begin
            step(0, 1, 8'(i), 16'hDEAD, 2'b11);
            if (BUSY === 1'b1) nbusy++;
            n_tests++;
            if (BUSY !== exp_busy || Dv0 !== exp_dv || Do0 !== exp_do) begin
                n_fail++;
                $display("FAIL clear_window t=%0t busy=%b dv=%b do=%h required busy=%b dv=%b do=%h",
                         $time, BUSY, Dv0, Do0, exp_busy, exp_dv, exp_do);
            end
            if (exp_busy === 1'b0) break;
        end
        n_tests++;
        if (nbusy != 256) begin
            n_fail++;
            $display("FAIL busy_length got=%0d required=256", nbusy);
        end
        for (int i = 0; i < 256 + LAT; i++) begin
            step(0, (i < 256), 8'(i), 16'd0, 2'b00);
            n_tests++;
            if (BUSY !== exp_busy || Dv0 !== exp_dv || Do0 !== exp_do || (Dv0 === 1'b1 && Do0 !== 16'h0000)) begin
                n_fail++;
                $display("FAIL cleared_read t=%0t busy=%b dv=%b do=%h required busy=%b dv=%b do=%h",
                         $time, BUSY, Dv0, Do0, exp_busy, exp_dv, exp_do);
            end
        end
    endtask

    task automatic test_write_read();
        int perm [0:255];
        int j, t;
        for (int i = 0; i < 256; i++) begin
            perm[i] = i;
            step(0, 1, 8'(i), 16'(i), 2'b11);
            n_tests++;
            if (Dv0 !== 1'b0 || Do0 !== exp_do) begin
                n_fail++;
                $display("FAIL write_quiet t=%0t dv=%b do=%h required dv=0 do=%h", $time, Dv0, Do0, exp_do);
            end
        end
        for (int i = 255; i > 0; i--) begin
            j = $urandom_range(0, i);
            t = perm[i]; perm[i] = perm[j]; perm[j] = t;
        end
        for (int i = 0; i < 256 + LAT; i++) begin
            step(0, (i < 256), 8'(perm[i % 256]), 16'd0, 2'b00);
            n_tests++;
            if (BUSY !== exp_busy || Dv0 !== exp_dv || Do0 !== exp_do) begin
                n_fail++;
                $display("FAIL readback t=%0t dv=%b do=%h required dv=%b do=%h", $time, Dv0, Do0, exp_dv, exp_do);
            end
        end
    endtask

    task automatic test_byte_enable();
        logic [7:0]  a;
        logic [1:0]  we;
        step(0, 1, 8'd5, 16'hABCD, 2'b11);
        step(0, 1, 8'd5, 16'h1234, 2'b01);
        step(0, 1, 8'd5, 16'h0000, 2'b00);
        repeat (LAT) step(0, 0, 8'd0, 16'd0, 2'b00);
        n_tests++;
        if (Do0 !== 16'hAB34 || Do0 !== exp_do) begin
            n_fail++;
            $display("FAIL byte_lane_low got=%h required=ab34", Do0);
        end
        for (int i = 0; i < 120; i++) begin
            a  = 8'($urandom_range(0, 15));
            we = 2'($urandom_range(0, 3));
            step(0, 1, a, 16'($urandom), we);
            n_tests++;
            if (BUSY !== exp_busy || Dv0 !== exp_dv || Do0 !== exp_do) begin
                n_fail++;
                $display("FAIL byte_random t=%0t dv=%b do=%h required dv=%b do=%h", $time, Dv0, Do0, exp_dv, exp_do);
            end
        end
    endtask

    task automatic test_reset_mid_clear();
        int nbusy;
        step(1, 0, 8'd0, 16'd0, 2'b00);
        repeat (100) step(0, 0, 8'd0, 16'd0, 2'b00);
        step(1, 0, 8'd0, 16'd0, 2'b00);
        n_tests++;
        if (BUSY !== 1'b1 || Dv0 !== 1'b0 || Do0 !== 16'h0000) begin
            n_fail++;
            $display("FAIL mid_clear_reset busy=%b dv=%b do=%h required busy=1 dv=0 do=0000", BUSY, Dv0, Do0);
        end
        nbusy = (BUSY === 1'b1) ? 1 : 0;
        for (int i = 0; i < 262; i++) begin
            if (i == 200) step(0, 1, 8'd3, 16'h5555, 2'b11);
            else          step(0, 1, 8'd7, 16'd0, 2'b00);
            if (BUSY === 1'b1) nbusy++;
            n_tests++;
            if (BUSY !== exp_busy || Dv0 !== exp_dv || Do0 !== exp_do) begin
                n_fail++;
                $display("FAIL restart_window t=%0t busy=%b dv=%b do=%h required busy=%b dv=%b do=%h",
                         $time, BUSY, Dv0, Do0, exp_busy, exp_dv, exp_do);
            end
            if (exp_busy === 1'b0) break;
        end
        n_tests++;
        if (nbusy != 256) begin
            n_fail++;
            $display("FAIL restart_busy_length got=%0d required=256", nbusy);
        end
        step(0, 1, 8'd3, 16'd0, 2'b00);
        repeat (LAT) step(0, 0, 8'd0, 16'd0, 2'b00);
        n_tests++;
        if (Do0 !== 16'h0000 || Do0 !== exp_do) begin
            n_fail++;
            $display("FAIL busy_write_ignored got=%h required=0000", Do0);
        end
    endtask

    task automatic test_back_to_back();
        int ndv;
        ndv = 0;
        for (int i = 1; i <= 3; i++) step(0, 1, 8'(i), 16'($urandom), 2'b11);
        for (int i = 0; i < 3 + LAT + 1; i++) begin
            step(0, (i < 3), 8'(i + 1), 16'd0, 2'b00);
            if (Dv0 === 1'b1) ndv++;
            n_tests++;
            if (Dv0 !== exp_dv || Do0 !== exp_do || (i >= LAT - 1 && i < LAT + 2 && Dv0 !== 1'b1)) begin
                n_fail++;
                $display("FAIL back_to_back t=%0t dv=%b do=%h required dv=%b do=%h", $time, Dv0, Do0, exp_dv, exp_do);
            end
        end
        n_tests++;
        if (ndv != 3) begin
            n_fail++;
            $display("FAIL b2b_pulse_count got=%0d required=3", ndv);
        end
    endtask

    task automatic test_random();
        int op;
        for (int i = 0; i < 400; i++) begin
            op = $urandom_range(0, 3);
            case (op)
                0:       step(0, 0, 8'($urandom), 16'($urandom), 2'($urandom));
                1:       step(0, 1, 8'($urandom), 16'($urandom), 2'($urandom_range(1, 3)));
                default: step(0, 1, 8'($urandom), 16'($urandom), 2'b00);
            endcase
            n_tests++;
            if (BUSY !== exp_busy || Dv0 !== exp_dv || Do0 !== exp_do) begin
                n_fail++;
                $display("FAIL random_ops t=%0t busy=%b dv=%b do=%h required busy=%b dv=%b do=%h",
                         $time, BUSY, Dv0, Do0, exp_busy, exp_dv, exp_do);
            end
        end
    endtask

    task automatic test_out_of_range();
        int n;
        @(negedge CLK); rst_s = 1'b1;
        @(posedge CLK); #1;
        n_tests++;
        if (busy_s !== 1'b1 || dv_s !== 1'b0 || do_s !== 16'h0000) begin
            n_fail++;
            $display("FAIL small_reset busy=%b dv=%b do=%h required busy=1 dv=0 do=0000", busy_s, dv_s, do_s);
        end
        @(negedge CLK); rst_s = 1'b0;
        n = 1;
        while (busy_s === 1'b1 && n < 400) begin
            @(posedge CLK); #1;
            if (busy_s === 1'b1) n++;
        end
        n_tests++;
        if (n != 200) begin
            n_fail++;
            $display("FAIL small_busy_length got=%0d required=200", n);
        end
        @(negedge CLK); en_s = 1'b1; we_s = 2'b11; a_s = 8'd199; di_s = 16'h1234;
        @(negedge CLK); a_s = 8'd210; di_s = 16'hFFFF;
        @(negedge CLK); we_s = 2'b00; a_s = 8'd199;
        repeat (LAT) @(posedge CLK);
        #1;
        n_tests++;
        if (dv_s !== 1'b1 || do_s !== 16'h1234) begin
            n_fail++;
            $display("FAIL last_word dv=%b do=%h required dv=1 do=1234", dv_s, do_s);
        end
        @(negedge CLK); a_s = 8'd210;
        repeat (LAT) @(posedge CLK);
        #1;
        n_tests++;
        if (dv_s !== 1'b1 || do_s !== 16'h0000) begin
            n_fail++;
            $display("FAIL oor_read dv=%b do=%h required dv=1 do=0000", dv_s, do_s);
        end
        @(negedge CLK); en_s = 1'b0;
        repeat (LAT) @(posedge CLK);
        #1;
        n_tests++;
        if (dv_s !== 1'b0 || do_s !== 16'h0000) begin
            n_fail++;
            $display("FAIL oor_idle dv=%b do=%h required dv=0 do=0000", dv_s, do_s);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_byte_enable();
        test_reset_mid_clear();
        test_back_to_back();
        test_random();
        test_out_of_range();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
